// File: rtl/vx_stream_arbiter.sv
// vx_stream_arbiter: N-way valid/ready arbiter feeding a 2-entry skid FIFO.
// Ports: clk, reset (async, active-low), valid_in/data_in/ready_in per input,
//        valid_out/data_out/sel_out toward the consumer, ready_out from it.

module VX_generic_arbiter #(
    parameter int NUM_REQS    = 4,
    parameter     TYPE        = "R",
    parameter bit LOCK_ENABLE = 1'b0,
    parameter int LOGW        = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                unlock,
    output logic [LOGW-1:0]     grant_index,
    output logic [NUM_REQS-1:0] grant_onehot
);
    logic [LOGW-1:0] ptr_q, ptr_d;
    logic            lock_q, lock_d;
    logic [LOGW-1:0] lidx_q, lidx_d;
    logic [LOGW-1:0] pick;
    logic            pick_v;
    logic            grant_valid;
    logic [LOGW-1:0] start;
    logic [LOGW:0]   sum;

    // Walk offsets from farthest to nearest so the nearest requester
    // (relative to the priority pointer) is the one left standing.
    always_comb begin
        pick   = '0;
        pick_v = 1'b0;
        start  = (TYPE == "R") ? ptr_q : '0;
        sum    = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            sum = {1'b0, start} + (LOGW+1)'(k);
            if (sum >= (LOGW+1)'(NUM_REQS)) begin
                sum = sum - (LOGW+1)'(NUM_REQS);
            end
            if (requests[sum[LOGW-1:0]]) begin
                pick   = sum[LOGW-1:0];
                pick_v = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        lock_d = lock_q;
        lidx_d = lidx_q;
        if (LOCK_ENABLE && lock_q) begin
            grant_index = lidx_q;
            grant_valid = 1'b1;
        end else begin
            grant_index = pick;
            grant_valid = pick_v;
        end
        if (unlock) begin
            lock_d = 1'b0;
            if (grant_index == LOGW'(NUM_REQS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_index + 1'b1;
            end
        end else if (LOCK_ENABLE && grant_valid) begin
            // Granted but not taken: pin the grant until it fires.
            lock_d = 1'b1;
            lidx_d = grant_index;
        end
    end

    assign grant_onehot = grant_valid ? (NUM_REQS'(1) << grant_index) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
            lidx_q <= lidx_d;
        end
    end
endmodule

module vx_stream_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int DATAW       = 32,
    parameter     ARBITER     = "R",
    parameter bit LOCK_ENABLE = 1'b0,
    parameter int SELW        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0] data_in,
    output logic [NUM_INPUTS-1:0]       ready_in,
    output logic                        valid_out,
    output logic [DATAW-1:0]            data_out,
    output logic [SELW-1:0]             sel_out,
    input  logic                        ready_out
);
    logic [NUM_INPUTS-1:0] grant_oh;
    logic [SELW-1:0]       grant_idx;
    logic [1:0]            count_q, count_d;
    logic [DATAW-1:0]      data0_q, data0_d;
    logic [DATAW-1:0]      data1_q, data1_d;
    logic [SELW-1:0]       sel0_q, sel0_d;
    logic [SELW-1:0]       sel1_q, sel1_d;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [DATAW-1:0]      push_data;

    if (NUM_INPUTS == 1) begin : g_bypass
        assign grant_oh  = 1'b1;
        assign grant_idx = '0;
    end else begin : g_arb
        VX_generic_arbiter #(
            .NUM_REQS    (NUM_INPUTS),
            .TYPE        (ARBITER),
            .LOCK_ENABLE (LOCK_ENABLE),
            .LOGW        (SELW)
        ) u_arb (
            .clk          (clk),
            .reset        (reset),
            .requests     (valid_in),
            .unlock       (push),
            .grant_index  (grant_idx),
            .grant_onehot (grant_oh)
        );
    end

    // Occupancy is registered, so ready_in never sees ready_out; gating
    // with reset keeps ready_in low while reset is held.
    assign full      = (count_q == 2'd2);
    assign ready_in  = grant_oh & {NUM_INPUTS{reset && !full}};
    assign push      = |(valid_in & ready_in);
    assign pop       = (count_q != 2'd0) && ready_out;
    assign push_data = data_in[grant_idx*DATAW +: DATAW];

    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        sel0_d  = sel0_q;
        sel1_d  = sel1_q;
        if (pop) begin
            data0_d = data1_q;
            sel0_d  = sel1_q;
        end
        if (push) begin
            // New item goes behind whatever survives this cycle.
            if (count_q == 2'd0 || pop) begin
                data0_d = push_data;
                sel0_d  = grant_idx;
            end else begin
                data1_d = push_data;
                sel1_d  = grant_idx;
            end
        end
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            data0_q <= '0;
            data1_q <= '0;
            sel0_q  <= '0;
            sel1_q  <= '0;
        end else begin
            count_q <= count_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            sel0_q  <= sel0_d;
            sel1_q  <= sel1_d;
        end
    end

    assign valid_out = (count_q != 2'd0);
    assign data_out  = data0_q;
    assign sel_out   = sel0_q;
endmodule

// File: doc/vx_stream_arbiter.md
Name: vx_stream_arbiter

Overview:
- Multi-input valid/ready stream arbiter. Selects one of NUM_INPUTS producer streams per cycle using an internal VX_generic_arbiter instance, and forwards the winning payload plus its source index through a 2-entry output skid buffer.
- Sits between per-core/per-bank request queues and a single shared consumer (memory or cache port).
- Sustains one transfer per cycle, with ready_in independent of ready_out combinationally.

Parameters:
- NUM_INPUTS, 4, number of input streams (>=1).
- DATAW, 32, payload width in bits.
- ARBITER, "R", arbitration policy passed to VX_generic_arbiter ("R" round-robin, "P" fixed priority, lowest index wins).
- LOCK_ENABLE, 0, when 1 the grant is held on the same input until that input's transfer fires.
- SELW, LOG2UP(NUM_INPUTS), width of source index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- valid_in  input  NUM_INPUTS  per-input valid.
- data_in  input  NUM_INPUTS*DATAW  per-input payload; input i at bits [i*DATAW +: DATAW].
- ready_in  output  NUM_INPUTS  per-input ready.
- valid_out  output  1  output valid.
- data_out  output  DATAW  head payload.
- sel_out  output  SELW  source index of head payload.
- ready_out  input  1  consumer ready.

Behaviour:
- Input fire: valid_in[i] && ready_in[i]. At most one input fires per cycle.
- Output fire: valid_out && ready_out.
- ready_in[i] = grant_onehot[i] && (count != 2).
  - count is the registered buffer occupancy (0..2).
  - ready_in never depends combinationally on ready_out.
- Arbiter interface:
  - requests = valid_in.
  - unlock = input fire.
  - Round-robin mode: after input i fires, priority begins at i+1 mod NUM_INPUTS.
  - Round-robin with no fire: the priority pointer does not move.
- Latency: a payload accepted in cycle N appears on data_out/sel_out with valid_out=1 in cycle N+1 if the buffer was empty.
- Buffer:
  - Strict FIFO order, 2 entries; head drives data_out/sel_out.
  - valid_out = (count != 0).
- Count update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged, and the new item lands behind the remaining entry.
  - count==0: pop is impossible (valid_out=0).
  - count==2: push is impossible (ready_in all 0).
- data_out/sel_out are held stable while valid_out=1 and ready_out=0 (AXI-style: no retraction, no change).
- LOCK_ENABLE=1: once input i is granted, grant stays on i, even if valid_in[i] drops, until i fires.
- NUM_INPUTS=1:
  - The arbiter is bypassed.
  - ready_in[0] = (count != 2).
  - sel_out is constant 0.
- Reset (asynchronous assert, synchronous deassert is the integrator's concern):
  - count=0, valid_out=0, ready_in=0, data_out=0, sel_out=0.
  - Round-robin pointer set so input 0 has highest priority.
  - Reset mid-operation discards buffered entries. No transfer is reported in the reset cycle.
- ready_in may be 1 only while reset is deasserted.
- Width rules:
  - sel_out is the binary index of the granted input, zero-extended to SELW.
  - data_out is passed through unmodified.

Test Plan:
- Single stream: NUM_INPUTS=4, only valid_in[2]=1 with data 0xA0,0xA1,0xA2 back-to-back, ready_out=1 -> valid_out from cycle 1, data_out 0xA0,0xA1,0xA2 on consecutive cycles, sel_out=2, no bubbles.
- Round-robin fairness: valid_in=4'b1111 held for 8 cycles, ready_out=1 -> sel_out sequence 0,1,2,3,0,1,2,3.
- Fixed priority: ARBITER="P", valid_in=4'b1010 for 3 cycles -> sel_out=1,1,1; input 3 is never granted.
- Backpressure: ready_out=0 with valid_in[0]=1 streaming 0x10,0x11,0x12 -> exactly 2 accepted (count=2), ready_in=0, data_out held at 0x10. Raise ready_out -> 0x10,0x11,0x12 emerge in order, nothing lost or duplicated.
- Lock: LOCK_ENABLE=1, ARBITER="R", valid_in[1] asserted then dropped before fire while valid_in[3]=1 -> ready_in[3] stays 0 until input 1 reasserts and fires.
- Reset mid-operation: with count=2 and valid_out=1, drive reset=0 for one cycle asynchronously between edges -> valid_out=0, ready_in=0, data_out=0, sel_out=0 immediately. After release with valid_in=4'b1111 -> first grant is input 0.
